// File: rtl/cmt_pkg.sv
// Shared constants for the compare-match timer: prescaler width, clock-select
// encodings and the prescaler bit mask that defines a tick for each encoding.
package cmt_pkg;

  localparam int PRE_W = 9;

  typedef enum logic [1:0] {
    CKS_DIV8   = 2'b00,
    CKS_DIV32  = 2'b01,
    CKS_DIV128 = 2'b10,
    CKS_DIV512 = 2'b11
  } cks_e;

  localparam logic [PRE_W-1:0] MASK_DIV8   = 9'h007;
  localparam logic [PRE_W-1:0] MASK_DIV32  = 9'h01F;
  localparam logic [PRE_W-1:0] MASK_DIV128 = 9'h07F;
  localparam logic [PRE_W-1:0] MASK_DIV512 = 9'h1FF;

  // A tick fires when every prescaler bit under this mask is one.
  function automatic logic [PRE_W-1:0] pre_mask(input logic [1:0] cks);
    logic [PRE_W-1:0] m;
    case (cks_e'(cks))
      CKS_DIV8:   m = MASK_DIV8;
      CKS_DIV32:  m = MASK_DIV32;
      CKS_DIV128: m = MASK_DIV128;
      default:    m = MASK_DIV512;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cmt_cnt_ctrl_if.sv
// One timer channel's control/status bundle. There is no valid/ready
// handshake: run enable, clock select and compare value are levels, set_cnt
// is a single-cycle strobe qualifying wdata_cnt, and cnt/cmf are registered.
interface cmt_cnt_ctrl_if #(
  parameter int CW = 16
);
  logic          str;
  logic [1:0]    cks;
  logic          set_cnt;
  logic [CW-1:0] wdata_cnt;
  logic [CW-1:0] cmp;
  logic [CW-1:0] cnt;
  logic          cmf;

  modport master (
    output str, cks, set_cnt, wdata_cnt, cmp,
    input  cnt, cmf
  );

  modport slave (
    input  str, cks, set_cnt, wdata_cnt, cmp,
    output cnt, cmf
  );
endinterface

// File: rtl/cmt_cnt_ch.sv
// One compare-match timer channel: free-running prescaler gated by str, an
// up-counter advanced on each tick, cleared with a one-cycle cmf on match.
module cmt_cnt_ch
  import cmt_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cmt_cnt_ctrl_if.slave ch
);

  logic [PRE_W-1:0] pre_q;
  logic [CW-1:0]    cnt_q;
  logic             cmf_q;
  logic [PRE_W-1:0] mask;
  logic             tick;

  assign mask = pre_mask(ch.cks);
  assign tick = ch.str && ((pre_q & mask) == mask);

  // A CPU write wins over a same-cycle tick and swallows its match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      cmf_q <= 1'b0;
    end else begin
      pre_q <= ch.str ? pre_q + 1'b1 : '0;
      cmf_q <= 1'b0;
      if (ch.set_cnt) begin
        cnt_q <= ch.wdata_cnt;
      end else if (tick) begin
        if (cnt_q == ch.cmp) begin
          cnt_q <= '0;
          cmf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign ch.cnt = cnt_q;
  assign ch.cmf = cmf_q;

endmodule

// File: rtl/cmt_cnt_ctrl.sv
// Two-channel compare-match timer; each channel is an independent
// cmt_cnt_ch bound to its own cmt_cnt_ctrl_if bundle.
module cmt_cnt_ctrl
  import cmt_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          str0_i,
  input  logic          str1_i,
  input  logic [1:0]    cks0_i,
  input  logic [1:0]    cks1_i,
  input  logic          set_cnt0_i,
  input  logic          set_cnt1_i,
  input  logic [CW-1:0] wdata_cnt0_i,
  input  logic [CW-1:0] wdata_cnt1_i,
  input  logic [CW-1:0] const0_i,
  input  logic [CW-1:0] const1_i,
  output logic [CW-1:0] cnt0_o,
  output logic [CW-1:0] cnt1_o,
  output logic          cmf0_o,
  output logic          cmf1_o
);

  cmt_cnt_ctrl_if #(.CW(CW)) ch0_if ();
  cmt_cnt_ctrl_if #(.CW(CW)) ch1_if ();

  assign ch0_if.str       = str0_i;
  assign ch0_if.cks       = cks0_i;
  assign ch0_if.set_cnt   = set_cnt0_i;
  assign ch0_if.wdata_cnt = wdata_cnt0_i;
  assign ch0_if.cmp       = const0_i;

  assign ch1_if.str       = str1_i;
  assign ch1_if.cks       = cks1_i;
  assign ch1_if.set_cnt   = set_cnt1_i;
  assign ch1_if.wdata_cnt = wdata_cnt1_i;
  assign ch1_if.cmp       = const1_i;

  cmt_cnt_ch #(.CW(CW)) u_ch0 (
    .clk   (clk),
    .rst_n (rst_n),
    .ch    (ch0_if.slave)
  );

  cmt_cnt_ch #(.CW(CW)) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .ch    (ch1_if.slave)
  );

  assign cnt0_o = ch0_if.cnt;
  assign cmf0_o = ch0_if.cmf;
  assign cnt1_o = ch1_if.cnt;
  assign cmf1_o = ch1_if.cmf;

endmodule

// File: tb/tb_cmt_cnt_ctrl.sv
// Directed bench for cmt_cnt_ctrl: cmf pulses are scored against an expected
// queue of cycle numbers per channel; counter values are checked in-line.
module tb_cmt_cnt_ctrl;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];

  cmt_cnt_ctrl_if #(.CW(CW)) ch0 ();
  cmt_cnt_ctrl_if #(.CW(CW)) ch1 ();

  cmt_cnt_ctrl #(.CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .str0_i       (ch0.str),
    .str1_i       (ch1.str),
    .cks0_i       (ch0.cks),
    .cks1_i       (ch1.cks),
    .set_cnt0_i   (ch0.set_cnt),
    .set_cnt1_i   (ch1.set_cnt),
    .wdata_cnt0_i (ch0.wdata_cnt),
    .wdata_cnt1_i (ch1.wdata_cnt),
    .const0_i     (ch0.cmp),
    .const1_i     (ch1.cmp),
    .cnt0_o       (ch0.cnt),
    .cnt1_o       (ch1.cnt),
    .cmf0_o       (ch0.cmf),
    .cmf1_o       (ch1.cmf)
  );

  // Clock / reset / cycle counter; cyc == n after the n-th rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scoreboard monitor: every cmf pulse must match the head of its queue,
  // and an expected pulse that has gone past is reported as missed.
  always @(negedge clk) begin
    if (ch0.cmf) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL cmf0_unexpected actual=cyc %0d required=none", cyc);
      end else if (exp0_q[0] != 32'(cyc)) begin
        errors++;
        $display("FAIL cmf0_time actual=cyc %0d required=cyc %0d", cyc, exp0_q[0]);
        void'(exp0_q.pop_front());
      end else begin
        void'(exp0_q.pop_front());
      end
    end else if (exp0_q.size() != 0 && 32'(cyc) >= exp0_q[0]) begin
      checks++;
      errors++;
      $display("FAIL cmf0_missed actual=none required=cyc %0d", exp0_q[0]);
      void'(exp0_q.pop_front());
    end
    if (ch1.cmf) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL cmf1_unexpected actual=cyc %0d required=none", cyc);
      end else if (exp1_q[0] != 32'(cyc)) begin
        errors++;
        $display("FAIL cmf1_time actual=cyc %0d required=cyc %0d", cyc, exp1_q[0]);
        void'(exp1_q.pop_front());
      end else begin
        void'(exp1_q.pop_front());
      end
    end else if (exp1_q.size() != 0 && 32'(cyc) >= exp1_q[0]) begin
      checks++;
      errors++;
      $display("FAIL cmf1_missed actual=none required=cyc %0d", exp1_q[0]);
      void'(exp1_q.pop_front());
    end
  end

  initial begin
    int s;
    int r;
    rst_n         = 1'b0;
    ch0.str       = 1'b0; ch1.str       = 1'b0;
    ch0.cks       = 2'b00; ch1.cks      = 2'b00;
    ch0.set_cnt   = 1'b0; ch1.set_cnt   = 1'b0;
    ch0.wdata_cnt = '0;   ch1.wdata_cnt = '0;
    ch0.cmp       = '0;   ch1.cmp       = '0;

    run_to(2);
    check("rst_cnt0", 32'(ch0.cnt), 32'h0);
    check("rst_cnt1", 32'(ch1.cnt), 32'h0);
    check("rst_cmf0", 32'(ch0.cmf), 32'h0);
    check("rst_cmf1", 32'(ch1.cmf), 32'h0);
    run_to(3);
    rst_n = 1'b1;

    // ch0: /8, const 3 -> match every 32; ch1: /512, const 0 -> match every 512.
    run_to(5);
    s = cyc;
    ch0.cks = 2'b00; ch0.cmp = 16'd3; ch0.str = 1'b1;
    ch1.cks = 2'b11; ch1.cmp = 16'd0; ch1.str = 1'b1;
    exp0_q.push_back(32'(s + 32));
    exp0_q.push_back(32'(s + 64));
    exp1_q.push_back(32'(s + 512));
    exp1_q.push_back(32'(s + 1024));
    run_to(s + 7);  check("cnt0_pre_tick", 32'(ch0.cnt), 32'd0);
    run_to(s + 8);  check("cnt0_seq1", 32'(ch0.cnt), 32'd1);
    run_to(s + 16); check("cnt0_seq2", 32'(ch0.cnt), 32'd2);
    run_to(s + 24); check("cnt0_seq3", 32'(ch0.cnt), 32'd3);
    run_to(s + 32); check("cnt0_seq0", 32'(ch0.cnt), 32'd0);
    run_to(s + 40); check("cnt0_seq1b", 32'(ch0.cnt), 32'd1);

    // Load 0xFFFE with const 2: wrap passes through 0 without a match.
    run_to(s + 68);
    ch0.set_cnt = 1'b1; ch0.wdata_cnt = 16'hFFFE; ch0.cmp = 16'd2;
    run_to(s + 69);
    ch0.set_cnt = 1'b0;
    check("load_fffe", 32'(ch0.cnt), 32'hFFFE);
    exp0_q.push_back(32'(s + 104));
    run_to(s + 72);  check("wrap_ffff", 32'(ch0.cnt), 32'hFFFF);
    run_to(s + 80);  check("wrap_0", 32'(ch0.cnt), 32'h0);
    run_to(s + 88);  check("wrap_1", 32'(ch0.cnt), 32'h1);
    run_to(s + 96);  check("wrap_2", 32'(ch0.cnt), 32'h2);
    run_to(s + 104); check("wrap_match", 32'(ch0.cnt), 32'h0);

    // Write lands on the edge of a matching tick (cnt 2 == const 2).
    run_to(s + 127);
    check("pre_set_cnt", 32'(ch0.cnt), 32'h2);
    ch0.set_cnt = 1'b1; ch0.wdata_cnt = 16'h0010;
    run_to(s + 128);
    ch0.set_cnt = 1'b0;
    check("set_beats_tick", 32'(ch0.cnt), 32'h0010);
    check("set_no_cmf", 32'(ch0.cmf), 32'h0);
    run_to(s + 129);
    ch0.set_cnt = 1'b1; ch0.wdata_cnt = 16'd3; ch0.cmp = 16'd9;
    run_to(s + 130);
    ch0.set_cnt = 1'b0;

    // Stop at cnt 5 for 100 clocks, restart, first increment 8 clocks later.
    run_to(s + 144);
    check("cnt0_before_stop", 32'(ch0.cnt), 32'd5);
    ch0.str = 1'b0;
    run_to(s + 200);
    check("cnt0_hold", 32'(ch0.cnt), 32'd5);
    check("cnt1_indep", 32'(ch1.cnt), 32'd0);
    run_to(s + 244);
    ch0.str = 1'b1;
    run_to(s + 251); check("restart_7clk", 32'(ch0.cnt), 32'd5);
    run_to(s + 252); check("restart_8clk", 32'(ch0.cnt), 32'd6);
    ch0.str = 1'b0;

    run_to(s + 512);  check("cnt1_zero_a", 32'(ch1.cnt), 32'd0);
    run_to(s + 1024); check("cnt1_zero_b", 32'(ch1.cnt), 32'd0);
    run_to(s + 1030);
    ch1.str = 1'b0;

    // Reset asserted in the cycle whose closing edge would be a match tick.
    run_to(s + 1040);
    r = cyc;
    ch0.cmp = 16'd7; ch0.str = 1'b1;
    run_to(r + 8);
    check("pre_rst_cnt0", 32'(ch0.cnt), 32'd7);
    run_to(r + 15);
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt0", 32'(ch0.cnt), 32'd0);
    check("async_rst_cmf0", 32'(ch0.cmf), 32'd0);
    run_to(r + 18);
    rst_n = 1'b1;
    exp0_q.push_back(32'(r + 82));
    run_to(r + 19); check("post_rst_cnt0", 32'(ch0.cnt), 32'd0);
    run_to(r + 74); check("post_rst_cnt7", 32'(ch0.cnt), 32'd7);
    run_to(r + 82); check("post_rst_match", 32'(ch0.cnt), 32'd0);
    run_to(r + 90);
    ch0.str = 1'b0;
    run_to(r + 95);

    check("exp0_drained", 32'(exp0_q.size()), 32'd0);
    check("exp1_drained", 32'(exp1_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmt_cnt_ctrl.md
CMT_CNT_CTRL -- requirements
Module: cmt_cnt_ctrl

Interface
REQ-001 SHALL have parameter CW, default 16: counter and compare width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports str0_i / str1_i, input, 1 each: channel run enable, level.
REQ-005 SHALL have ports cks0_i / cks1_i, input, 2 each: prescale select (00 /8, 01 /32, 10 /128, 11 /512).
REQ-006 SHALL have ports set_cnt0_i / set_cnt1_i, input, 1 each: one-cycle CPU counter-write strobe.
REQ-007 SHALL have ports wdata_cnt0_i / wdata_cnt1_i, input, CW each: counter load value, valid with strobe.
REQ-008 SHALL have ports const0_i / const1_i, input, CW each: compare constant, level.
REQ-009 SHALL have ports cnt0_o / cnt1_o, output, CW each: registered counter value.
REQ-010 SHALL have ports cmf0_o / cmf1_o, output, 1 each: registered one-cycle compare-match pulse.

Function (per channel n; channels fully independent)
REQ-011 SHALL hold a 9-bit prescaler that increments by 1 each cycle while strn_i=1 and clears to 0 in any cycle strn_i=0.
REQ-012 SHALL raise internal tick in a cycle when strn_i=1 and the low k prescaler bits are all ones (k=3/5/7/9 per cksn_i); first tick comes on the 8th/32nd/128th/512th cycle after strn_i rises.
REQ-013 SHALL apply a cksn_i change immediately, without clearing the prescaler.
REQ-014 SHALL, on tick with cntn_o==constn_i, load cntn_o with 0 and assert cmfn_o for exactly the next cycle.
REQ-015 SHALL, on tick with cntn_o!=constn_i, increment cntn_o by 1 modulo 2^CW (0xFFFF wraps to 0x0000 without cmf).
REQ-016 SHALL, on set_cntn_i=1, load cntn_o with wdata_cntn_i next cycle regardless of strn_i; set beats same-cycle tick, and that tick produces neither increment nor cmf.
REQ-017 SHALL leave the prescaler unaffected by set_cntn_i.
REQ-018 SHALL hold cntn_o while strn_i=0; a later restart resumes from the held value.
REQ-019 SHALL, with constn_i=0, hold cntn_o at 0 and pulse cmfn_o once per tick.
REQ-020 SHALL, with a loaded cntn_o > constn_i, count up through wrap to 0 then match at constn_i; no match on the way.
REQ-021 SHALL sample constn_i only at tick; a change takes effect on the next tick.
REQ-022 SHALL give match period of (constn_i+1) ticks, i.e. (constn_i+1)*divisor clocks.

Reset
REQ-023 SHALL, while rst_n=0, force cnt0_o, cnt1_o, both prescalers to 0 and cmf0_o, cmf1_o to 0, asynchronously.
REQ-024 SHALL, on reset mid-count, discard any pending cmf pulse; after release, behave as from power-up.

Structure
REQ-025 SHALL implement one channel as sub-module cmt_cnt_ch, instantiated twice.
REQ-026 SHALL place CKS encodings and the prescaler mask per encoding (0x007, 0x01F, 0x07F, 0x1FF) in shared package cmt_pkg, together with the 9-bit prescaler width constant.
REQ-027 SHALL keep all outputs registered; no combinational path from any input to any output.

Verification
REQ-028 SHALL cover: cks0=00, const0=3, str0 1 -> cmf0_o pulses every 32 clocks; cnt0_o sequence 0,1,2,3,0.
REQ-029 SHALL cover: cks1=11, const1=0, str1 1 -> cnt1_o stays 0, cmf1_o first at clock 513, then every 512.
REQ-030 SHALL cover: set_cnt0 with 0xFFFE, const0=2, cks0=00 -> cnt0_o 0xFFFE, 0xFFFF, 0, 1, 2, then cmf0_o and 0; no cmf at wrap.
REQ-031 SHALL cover: set_cnt0 with 0x0010 in same cycle as a matching tick -> cnt0_o=0x0010, cmf0_o stays 0.
REQ-032 SHALL cover: str0 dropped at cnt0_o=5 for 100 clocks, then raised -> cnt0_o holds 5; next increment exactly 8 clocks (cks0=00) after restart; channel 1 unaffected throughout.
REQ-033 SHALL cover: rst_n asserted in the cycle a match tick occurs -> cnt0_o=0, cmf0_o=0 immediately; no pulse after release.
